// File: rtl/axis_1553_decoder.sv
// axis_1553_decoder: MIL-STD-1553 Manchester receive decoder with an AXI-Stream master output.
// Recovers the sync type, 16 data bits (MSB first) and the parity bit from the diff/en_diff line pair.
// Optional build macro DECODER_STATS_EN adds saturating word/error/parity/overrun counters.
module axis_1553_decoder #(
    parameter int clock_speed = 16000000,
    parameter int sync_tol    = 2
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic        parity_set,
    input  logic [1:0]  diff,
    input  logic        en_diff,
    output logic [15:0] m_axis_tdata,
    output logic [7:0]  m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        rx_error,
    output logic        rx_overrun
`ifdef DECODER_STATS_EN
    ,
    output logic [15:0] stat_words,
    output logic [15:0] stat_errors,
    output logic [15:0] stat_parity,
    output logic [15:0] stat_overrun
`endif
);

    localparam int CPB       = clock_speed / 1000000;
    localparam int HALF_SYNC = 3 * CPB / 2;
    localparam int RUN_MAX   = 4 * CPB;
    localparam int RUN_W     = $clog2(RUN_MAX + 1);
    localparam int TMR_W     = $clog2(HALF_SYNC + 1);

    localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(RUN_MAX);
    localparam logic [RUN_W:0]   SYNC_LO  = (RUN_W + 1)'(HALF_SYNC - sync_tol);
    localparam logic [RUN_W:0]   SYNC_HI  = (RUN_W + 1)'(HALF_SYNC + sync_tol);
    localparam logic [TMR_W-1:0] T_SYNC   = TMR_W'(HALF_SYNC - 1);
    localparam logic [TMR_W-1:0] T_A      = TMR_W'(CPB / 4);
    localparam logic [TMR_W-1:0] T_B      = TMR_W'(3 * CPB / 4);
    localparam logic [TMR_W-1:0] T_WRAP   = TMR_W'(CPB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_BITS = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic             rst_m;
    logic             rst_s;
    logic [2:0]       sync_m;
    logic [2:0]       sync_s;
    logic [1:0]       line;
    logic [1:0]       line_q;
    logic             change;
    logic [RUN_W-1:0] run;
    logic [RUN_W:0]   dur;
    logic [1:0]       state;
    logic [TMR_W-1:0] tmr;
    logic [4:0]       bit_idx;
    logic [16:0]      shreg;
    logic [2:0]       sync_type;
    logic             sync_lvl;
    logic [1:0]       samp_a;
    logic             perr;
    logic             load;
    logic             overrun;
    logic             sync_edge;

    // Reset bridge: assert immediately, release two clocks after arst falls.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rst_m <= 1'b1;
            rst_s <= 1'b1;
        end else begin
            rst_m <= 1'b0;
            rst_s <= rst_m;
        end
    end

    // Two-flop synchronizer for {en_diff, diff}.
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            sync_m <= '0;
            sync_s <= '0;
        end else begin
            sync_m <= {en_diff, diff};
            sync_s <= sync_m;
        end
    end

    // line = {active, level}; idle is always encoded as 2'b00 so idle-to-idle is not a change.
    assign line[1] = sync_s[2] & (sync_s[1] ^ sync_s[0]);
    assign line[0] = sync_s[2] & (sync_s[1:0] == 2'b01);
    assign change  = (line != line_q);

    // run holds (cycles the previous level lasted - 1) on the cycle of a change.
    assign dur = {1'b0, run} + (RUN_W + 1)'(1);

    // A sync edge: active level to the opposite active level after a 1.5-bit run.
    assign sync_edge = change && line_q[1] && line[1] && (line_q[0] != line[0]) &&
                       (dur >= SYNC_LO) && (dur <= SYNC_HI);

    // Run-length counter since the last line change, saturating so long idle never looks like sync.
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            line_q <= '0;
            run    <= '0;
        end else begin
            line_q <= line;
            if (change) begin
                run <= '0;
            end else if (run != RUN_SAT) begin
                run <= run + RUN_W'(1);
            end
        end
    end

    // Word-framing FSM: sync detect, second sync half check, then 17 fixed bit windows from the anchor.
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            state     <= S_IDLE;
            tmr       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            sync_type <= '0;
            sync_lvl  <= 1'b0;
            samp_a    <= '0;
            rx_error  <= 1'b0;
        end else begin
            rx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync_edge) begin
                        state     <= S_SYNC;
                        sync_lvl  <= line_q[0];
                        sync_type <= line_q[0] ? 3'b010 : 3'b100;
                        // The edge cycle itself is t0, so the first SYNC cycle is t0+1.
                        tmr       <= TMR_W'(1);
                    end
                end
                S_SYNC: begin
                    if (line != {1'b1, ~sync_lvl}) begin
                        rx_error <= 1'b1;
                        state    <= S_IDLE;
                    end else if (tmr == T_SYNC) begin
                        state   <= S_BITS;
                        tmr     <= '0;
                        bit_idx <= 5'd16;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_BITS: begin
                    tmr <= (tmr == T_WRAP) ? '0 : tmr + TMR_W'(1);
                    if (tmr == T_A) begin
                        samp_a <= line;
                    end
                    if (tmr == T_B) begin
                        if (!samp_a[1] || !line[1] || (samp_a[0] == line[0])) begin
                            rx_error <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            shreg <= {shreg[15:0], ~samp_a[0] & line[0]};
                            // Parity bit leaves at its B sample rather than at the window end.
                            if (bit_idx == 5'd0) begin
                                state <= S_DONE;
                            end else begin
                                bit_idx <= bit_idx - 5'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Total ones over data and parity compared against the requested parity sense.
    assign perr    = (^shreg) ^ parity_set;
    assign load    = (state == S_DONE) && (!m_axis_tvalid || m_axis_tready);
    assign overrun = (state == S_DONE) && !load;

    // AXI-Stream output register; a new word may replace one being accepted in the same cycle.
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= overrun;
            if (load) begin
                m_axis_tdata  <= shreg[16:1];
                m_axis_tuser  <= {sync_type, 4'b0000, perr};
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef DECODER_STATS_EN
    // Saturating event counters.
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            stat_words   <= '0;
            stat_errors  <= '0;
            stat_parity  <= '0;
            stat_overrun <= '0;
        end else begin
            if (load && (stat_words != 16'hFFFF)) begin
                stat_words <= stat_words + 16'd1;
            end
            if (rx_error && (stat_errors != 16'hFFFF)) begin
                stat_errors <= stat_errors + 16'd1;
            end
            if (load && perr && (stat_parity != 16'hFFFF)) begin
                stat_parity <= stat_parity + 16'd1;
            end
            if (rx_overrun && (stat_overrun != 16'hFFFF)) begin
                stat_overrun <= stat_overrun + 16'd1;
            end
        end
    end
`endif

endmodule
